lane_traffic_ctrl: RTL and testbench
====================================

LANE_TRAFFIC_CTRL -- requirements
Module: lane_traffic_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter NUM_CARS, default 10, SHALL set the number of independent cars.
REQ-003 Parameter COORD_W, default 6, SHALL set the bit width of each X and Y coordinate.
REQ-004 Parameter SPEED_W, default 3, SHALL set the bit width of each per-car speed.
REQ-005 Parameter c_MAX_X, default 20, SHALL set the grid width; legal X is 0..c_MAX_X-1 and c_MAX_X <= 2^COORD_W.
REQ-006 Parameter c_SLOW_COUNT, default 2000000, SHALL set the move period in clock cycles (>= 2).
REQ-007 Parameter COUNTER_WIDTH, default 26, SHALL set the slowdown counter width.
REQ-008 Port i_Clk, input, 1 bit: clock.
REQ-009 Port i_Reset, input, 1 bit: synchronous active-high reset.
REQ-010 Port i_Enable, input, 1 bit: 1 = run, 0 = hold.
REQ-011 Port i_Load, input, 1 bit: single-cycle request to reload initial positions.
REQ-012 Port i_Speed, input, NUM_CARS*SPEED_W bits: per-car speed in cells per move; car k uses bits [k*SPEED_W +: SPEED_W].
REQ-013 Port i_Dir, input, NUM_CARS bits: per-car direction; 0 = increasing X, 1 = decreasing X.
REQ-014 Ports i_Init_X and i_Init_Y, input, NUM_CARS*COORD_W bits each: flattened initial positions.
REQ-015 Ports o_Car_X and o_Car_Y, output, NUM_CARS*COORD_W bits each: registered, flattened current positions.
REQ-016 Port o_Tick, output, 1 bit: one-cycle pulse in the cycle in which the positions update.
REQ-017 Port o_Collision, output, NUM_CARS bits: bit k set when car k shares both X and Y with another car.

Function
REQ-018 The state machine SHALL have three states: LOAD, RUN and HOLD.
REQ-019 LOAD SHALL last exactly one cycle; in that cycle the block copies i_Init_X/Y to the positions, clears the counter, and then goes to RUN if i_Enable=1, otherwise to HOLD.
REQ-020 In RUN, the counter SHALL increment every cycle; when it equals c_SLOW_COUNT-1 it returns to 0, o_Tick=1 and every car moves once. The move period is exactly c_SLOW_COUNT cycles.
REQ-021 RUN SHALL go to HOLD when i_Enable=0; HOLD SHALL return to RUN when i_Enable=1. In HOLD the counter and positions freeze and o_Tick=0.
REQ-022 An i_Load=1 in RUN or HOLD SHALL force LOAD on the next cycle. i_Load takes priority over a coincident tick, and no move occurs in that cycle.
REQ-023 Increasing move: sum = X+speed, computed at COORD_W+1 bits; if sum >= c_MAX_X the new X is sum-c_MAX_X, otherwise it is sum (true modular wrap, not reset to 0).
REQ-024 Decreasing move: if X >= speed the new X is X-speed, otherwise it is X+c_MAX_X-speed.
REQ-025 A speed of 0 SHALL leave the car stationary; a speed >= c_MAX_X SHALL saturate to c_MAX_X-1.
REQ-026 An i_Init_X value >= c_MAX_X SHALL be loaded as 0.
REQ-027 i_Init_Y SHALL be loaded unchanged, and Y SHALL never change outside LOAD.
REQ-028 i_Speed and i_Dir SHALL be sampled in the tick cycle only, so changes between ticks have no effect.

Reset
REQ-029 While i_Reset=1, all of the following SHALL be 0: o_Car_X, o_Car_Y, o_Tick, o_Collision and the counter; the state SHALL be LOAD.
REQ-030 On the first cycle after i_Reset falls, LOAD SHALL execute.
REQ-031 An i_Reset asserted mid-operation SHALL override i_Load and the tick in the same cycle.

Configuration
REQ-032 Macro CAR_COLLISION_EN, when defined, SHALL compile in pairwise X/Y comparison. o_Collision is then registered and reflects the positions one cycle after each LOAD or tick, and holds its value otherwise.
REQ-033 Without CAR_COLLISION_EN, o_Collision SHALL be tied to 0 and no comparator logic shall exist.

Verification
REQ-034 Setup: c_SLOW_COUNT=4, c_MAX_X=20, i_Enable=1. Release reset with car0 Init_X=18, speed=3, dir=0. Required: o_Tick pulses 4 cycles after LOAD and every 4 cycles thereafter, and car0 X goes 18 -> 1 -> 4.
REQ-035 Car1 Init_X=1, speed=3, dir=1. Required: X goes 1 -> 18 -> 15.
REQ-036 Drop i_Enable for 10 cycles mid-period. Required: positions and counter freeze, no o_Tick, and the next tick arrives after the remaining counts with no skipped or extra move.
REQ-037 Assert i_Load in the same cycle as a tick. Required: no move; the next cycle shows the Init values and the next tick arrives 4 cycles after LOAD.
REQ-038 Car2 speed=0 and Init_X=25. Required: X loads as 0 and stays 0; car3 speed=7 with c_MAX_X=5 moves 4 cells per tick.
REQ-039 With CAR_COLLISION_EN defined, load car0 and car1 both at (5,2). Required: o_Collision[1:0]=2'b11 one cycle after LOAD. Without the macro, o_Collision stays 0.

Source files
------------

// File: rtl/lane_traffic_ctrl_if.sv
// lane_traffic_ctrl_if -- control and position bus of lane_traffic_ctrl.
//   master : the system side; it drives run/hold, load and the per-car configuration
//            and reads back positions, the move tick and collision flags.
//   slave  : the lane_traffic_ctrl side.
// Signals:
//   i_Enable    1 = run, 0 = hold
//   i_Load      single-cycle request to reload the initial positions
//   i_Speed     per-car speed, car k at [k*SPEED_W +: SPEED_W]
//   i_Dir       per-car direction, 0 = increasing X, 1 = decreasing X
//   i_Init_X/Y  flattened initial positions, car k at [k*COORD_W +: COORD_W]
//   o_Car_X/Y   registered, flattened current positions
//   o_Tick      one-cycle pulse when the positions have just moved
//   o_Collision bit k set when car k shares X and Y with another car
// The parameters must match those of the lane_traffic_ctrl that uses the bus.
interface lane_traffic_ctrl_if #(
  parameter int NUM_CARS = 10,
  parameter int COORD_W  = 6,
  parameter int SPEED_W  = 3
);
  logic                          i_Enable;
  logic                          i_Load;
  logic [NUM_CARS*SPEED_W-1:0]   i_Speed;
  logic [NUM_CARS-1:0]           i_Dir;
  logic [NUM_CARS*COORD_W-1:0]   i_Init_X;
  logic [NUM_CARS*COORD_W-1:0]   i_Init_Y;
  logic [NUM_CARS*COORD_W-1:0]   o_Car_X;
  logic [NUM_CARS*COORD_W-1:0]   o_Car_Y;
  logic                          o_Tick;
  logic [NUM_CARS-1:0]           o_Collision;

  modport master (
    output i_Enable, i_Load, i_Speed, i_Dir, i_Init_X, i_Init_Y,
    input  o_Car_X, o_Car_Y, o_Tick, o_Collision
  );

  modport slave (
    input  i_Enable, i_Load, i_Speed, i_Dir, i_Init_X, i_Init_Y,
    output o_Car_X, o_Car_Y, o_Tick, o_Collision
  );
endinterface

// File: rtl/lane_traffic_ctrl.sv
// lane_traffic_ctrl -- moves NUM_CARS independent cars along X on a c_MAX_X wide
// wrapping lane, one move every c_SLOW_COUNT clock cycles.
// Ports:
//   i_Clk    clock
//   i_Reset  synchronous active-high reset (positions, tick, collision, counter to 0,
//            state to LOAD; LOAD runs on the first cycle after release)
//   bus      lane_traffic_ctrl_if.slave (enable, load, speed, direction, initial
//            positions in; registered positions, tick and collision flags out)
// Optional feature:
//   CAR_COLLISION_EN  when defined, compiles in the pairwise X/Y comparator and a
//                     registered o_Collision refreshed one cycle after each LOAD or
//                     move; otherwise o_Collision is tied to 0.
module lane_traffic_ctrl #(
  parameter int NUM_CARS      = 10,
  parameter int COORD_W       = 6,
  parameter int SPEED_W       = 3,
  parameter int c_MAX_X       = 20,
  parameter int c_SLOW_COUNT  = 2000000,
  parameter int COUNTER_WIDTH = 26
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  lane_traffic_ctrl_if.slave bus
);

  // Arithmetic width: room for X + speed or X + c_MAX_X without overflow.
  localparam int AW = ((COORD_W > SPEED_W) ? COORD_W : SPEED_W) + 1;

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_HOLD} state_t;

  state_t                        state, state_nxt;
  logic [COUNTER_WIDTH-1:0]      cnt;
  logic [NUM_CARS*COORD_W-1:0]   car_x, car_y;
  logic [NUM_CARS*COORD_W-1:0]   x_moved, x_init;
  logic                          tick_now;
  logic                          tick_r;

  // Next state. A move happens only in RUN with enable high and no load request;
  // the HOLD->RUN transition cycle itself does not count.
  always_comb begin
    state_nxt = state;
    tick_now  = 1'b0;
    unique case (state)
      S_LOAD: state_nxt = bus.i_Enable ? S_RUN : S_HOLD;
      S_RUN: begin
        if (bus.i_Load)         state_nxt = S_LOAD;
        else if (!bus.i_Enable) state_nxt = S_HOLD;
        else                    tick_now  = (cnt == COUNTER_WIDTH'(c_SLOW_COUNT - 1));
      end
      S_HOLD: begin
        if (bus.i_Load)        state_nxt = S_LOAD;
        else if (bus.i_Enable) state_nxt = S_RUN;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  // Per-car move and load clamping. Speeds at or above c_MAX_X saturate to
  // c_MAX_X-1; wrap is modular in both directions.
  logic [AW-1:0] spd, xv, sum, nx, ix;
  always_comb begin
    x_moved = '0;
    x_init  = '0;
    spd     = '0;
    xv      = '0;
    sum     = '0;
    nx      = '0;
    ix      = '0;
    for (int unsigned k = 0; k < NUM_CARS; k++) begin
      spd = AW'(bus.i_Speed[k*SPEED_W +: SPEED_W]);
      if (spd >= AW'(c_MAX_X)) spd = AW'(c_MAX_X - 1);
      xv = AW'(car_x[k*COORD_W +: COORD_W]);
      if (!bus.i_Dir[k]) begin
        sum = xv + spd;
        nx  = (sum >= AW'(c_MAX_X)) ? sum - AW'(c_MAX_X) : sum;
      end else begin
        nx  = (xv >= spd) ? xv - spd : xv + AW'(c_MAX_X) - spd;
      end
      x_moved[k*COORD_W +: COORD_W] = nx[COORD_W-1:0];
      ix = AW'(bus.i_Init_X[k*COORD_W +: COORD_W]);
      x_init[k*COORD_W +: COORD_W] = (ix >= AW'(c_MAX_X)) ? '0 : ix[COORD_W-1:0];
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state  <= S_LOAD;
      cnt    <= '0;
      car_x  <= '0;
      car_y  <= '0;
      tick_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      tick_r <= tick_now;
      if (state == S_LOAD) begin
        car_x <= x_init;
        car_y <= bus.i_Init_Y;
        cnt   <= '0;
      end else if (state == S_RUN && bus.i_Enable && !bus.i_Load) begin
        if (tick_now) begin
          cnt   <= '0;
          car_x <= x_moved;
        end else begin
          cnt   <= cnt + 1'b1;
        end
      end
    end
  end

  assign bus.o_Car_X = car_x;
  assign bus.o_Car_Y = car_y;
  assign bus.o_Tick  = tick_r;

`ifdef CAR_COLLISION_EN
  logic                coll_upd;
  logic [NUM_CARS-1:0] coll_nxt, coll_r;

  always_comb begin
    coll_nxt = '0;
    for (int unsigned k = 0; k < NUM_CARS; k++) begin
      for (int unsigned j = 0; j < NUM_CARS; j++) begin
        if (j != k &&
            car_x[k*COORD_W +: COORD_W] == car_x[j*COORD_W +: COORD_W] &&
            car_y[k*COORD_W +: COORD_W] == car_y[j*COORD_W +: COORD_W])
          coll_nxt[k] = 1'b1;
      end
    end
  end

  // coll_upd marks the cycle right after positions changed (LOAD or move).
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      coll_upd <= 1'b0;
      coll_r   <= '0;
    end else begin
      coll_upd <= (state == S_LOAD) || tick_now;
      if (coll_upd) coll_r <= coll_nxt;
    end
  end

  assign bus.o_Collision = coll_r;
`else
  assign bus.o_Collision = '0;
`endif

endmodule

// File: tb/tb_lane_traffic_ctrl.sv
// Directed bench for lane_traffic_ctrl: instance A (c_MAX_X=20) covers reset, wrap in
// both directions, hold, load-on-tick, collision and reset override; instance B
// (c_MAX_X=5) covers speed saturation, init clamping and exact-boundary wrap.
module tb_lane_traffic_ctrl;
  localparam int NC = 4;
  localparam int CW = 6;
  localparam int SW = 3;

  logic clk;
  logic rst;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  lane_traffic_ctrl_if #(.NUM_CARS(NC), .COORD_W(CW), .SPEED_W(SW)) ba ();
  lane_traffic_ctrl_if #(.NUM_CARS(NC), .COORD_W(CW), .SPEED_W(SW)) bb ();

  lane_traffic_ctrl #(
    .NUM_CARS(NC), .COORD_W(CW), .SPEED_W(SW),
    .c_MAX_X(20), .c_SLOW_COUNT(4), .COUNTER_WIDTH(4)
  ) dut_a (
    .i_Clk(clk), .i_Reset(rst), .bus(ba)
  );

  lane_traffic_ctrl #(
    .NUM_CARS(NC), .COORD_W(CW), .SPEED_W(SW),
    .c_MAX_X(5), .c_SLOW_COUNT(4), .COUNTER_WIDTH(4)
  ) dut_b (
    .i_Clk(clk), .i_Reset(rst_b), .bus(bb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected collision bits for cars 0 and 1 sharing (5,2).
`ifdef CAR_COLLISION_EN
  localparam logic [NC-1:0] COLL_PAIR = 4'b0011;
`else
  localparam logic [NC-1:0] COLL_PAIR = 4'b0000;
`endif

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rst_b = 1'b1;
    ba.i_Enable = 1'b1;
    ba.i_Load   = 1'b0;
    ba.i_Speed  = {3'd2, 3'd0, 3'd3, 3'd3};
    ba.i_Dir    = 4'b0010;
    ba.i_Init_X = {6'd7, 6'd25, 6'd1, 6'd18};
    ba.i_Init_Y = {6'd3, 6'd2, 6'd1, 6'd0};
    bb.i_Enable = 1'b1;
    bb.i_Load   = 1'b0;
    bb.i_Speed  = {3'd7, 3'd3, 3'd0, 3'd7};
    bb.i_Dir    = 4'b0001;
    bb.i_Init_X = {6'd0, 6'd4, 6'd5, 6'd0};
    bb.i_Init_Y = {6'd3, 6'd2, 6'd1, 6'd0};
    repeat (3) cyc();
    checks++; if (ba.o_Car_X !== '0) begin errors++; $display("FAIL reset_x: got %h want 0", ba.o_Car_X); end
    checks++; if (ba.o_Car_Y !== '0) begin errors++; $display("FAIL reset_y: got %h want 0", ba.o_Car_Y); end
    checks++; if (ba.o_Tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", ba.o_Tick); end
    checks++; if (ba.o_Collision !== '0) begin errors++; $display("FAIL reset_coll: got %b want 0", ba.o_Collision); end
  endtask

  task automatic test_run();
    logic exp_tick;
    rst = 1'b0;
    cyc();  // LOAD executes
    checks++; if (ba.o_Car_X !== {6'd7, 6'd0, 6'd1, 6'd18}) begin errors++; $display("FAIL load_x: got %h want %h", ba.o_Car_X, {6'd7, 6'd0, 6'd1, 6'd18}); end
    checks++; if (ba.o_Car_Y !== {6'd3, 6'd2, 6'd1, 6'd0}) begin errors++; $display("FAIL load_y: got %h want %h", ba.o_Car_Y, {6'd3, 6'd2, 6'd1, 6'd0}); end
    for (int i = 1; i <= 8; i++) begin
      cyc();
      exp_tick = (i == 4 || i == 8);
      checks++; if (ba.o_Tick !== exp_tick) begin errors++; $display("FAIL run_tick[%0d]: got %b want %b", i, ba.o_Tick, exp_tick); end
      checks++; if (ba.o_Collision !== '0) begin errors++; $display("FAIL run_coll[%0d]: got %b want 0", i, ba.o_Collision); end
      if (i == 4) begin
        checks++; if (ba.o_Car_X !== {6'd9, 6'd0, 6'd18, 6'd1}) begin errors++; $display("FAIL move1_x: got %h want %h", ba.o_Car_X, {6'd9, 6'd0, 6'd18, 6'd1}); end
      end
      if (i == 8) begin
        checks++; if (ba.o_Car_X !== {6'd11, 6'd0, 6'd15, 6'd4}) begin errors++; $display("FAIL move2_x: got %h want %h", ba.o_Car_X, {6'd11, 6'd0, 6'd15, 6'd4}); end
        checks++; if (ba.o_Car_Y !== {6'd3, 6'd2, 6'd1, 6'd0}) begin errors++; $display("FAIL move2_y: got %h want %h", ba.o_Car_Y, {6'd3, 6'd2, 6'd1, 6'd0}); end
      end
    end
  endtask

  task automatic test_hold();
    cyc();
    cyc();  // counter now 2
    ba.i_Enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) ba.i_Speed = {3'd2, 3'd0, 3'd3, 3'd7};  // changed between ticks
      cyc();
      checks++; if (ba.o_Tick !== 1'b0) begin errors++; $display("FAIL hold_tick[%0d]: got %b want 0", i, ba.o_Tick); end
      checks++; if (ba.o_Car_X !== {6'd11, 6'd0, 6'd15, 6'd4}) begin errors++; $display("FAIL hold_x[%0d]: got %h want %h", i, ba.o_Car_X, {6'd11, 6'd0, 6'd15, 6'd4}); end
    end
    ba.i_Speed  = {3'd2, 3'd0, 3'd3, 3'd3};
    ba.i_Enable = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      checks++; if (ba.o_Tick !== (i == 3)) begin errors++; $display("FAIL resume_tick[%0d]: got %b want %b", i, ba.o_Tick, (i == 3)); end
    end
    checks++; if (ba.o_Car_X !== {6'd13, 6'd0, 6'd12, 6'd7}) begin errors++; $display("FAIL resume_x: got %h want %h", ba.o_Car_X, {6'd13, 6'd0, 6'd12, 6'd7}); end
  endtask

  task automatic test_load_on_tick();
    repeat (3) cyc();  // counter now at its last count
    ba.i_Load   = 1'b1;
    ba.i_Init_X = {6'd7, 6'd25, 6'd5, 6'd5};
    ba.i_Init_Y = {6'd3, 6'd2, 6'd2, 6'd2};
    cyc();
    ba.i_Load = 1'b0;
    checks++; if (ba.o_Tick !== 1'b0) begin errors++; $display("FAIL lot_tick: got %b want 0", ba.o_Tick); end
    checks++; if (ba.o_Car_X !== {6'd13, 6'd0, 6'd12, 6'd7}) begin errors++; $display("FAIL lot_nomove: got %h want %h", ba.o_Car_X, {6'd13, 6'd0, 6'd12, 6'd7}); end
    cyc();
    checks++; if (ba.o_Car_X !== {6'd7, 6'd0, 6'd5, 6'd5}) begin errors++; $display("FAIL lot_x: got %h want %h", ba.o_Car_X, {6'd7, 6'd0, 6'd5, 6'd5}); end
    checks++; if (ba.o_Car_Y !== {6'd3, 6'd2, 6'd2, 6'd2}) begin errors++; $display("FAIL lot_y: got %h want %h", ba.o_Car_Y, {6'd3, 6'd2, 6'd2, 6'd2}); end
    for (int i = 1; i <= 4; i++) begin
      cyc();
      if (i == 1) begin
        checks++; if (ba.o_Collision !== COLL_PAIR) begin errors++; $display("FAIL coll_pair: got %b want %b", ba.o_Collision, COLL_PAIR); end
      end
      checks++; if (ba.o_Tick !== (i == 4)) begin errors++; $display("FAIL lot_next_tick[%0d]: got %b want %b", i, ba.o_Tick, (i == 4)); end
    end
    checks++; if (ba.o_Car_X !== {6'd9, 6'd0, 6'd2, 6'd8}) begin errors++; $display("FAIL lot_move_x: got %h want %h", ba.o_Car_X, {6'd9, 6'd0, 6'd2, 6'd8}); end
    cyc();
    checks++; if (ba.o_Collision !== '0) begin errors++; $display("FAIL coll_clear: got %b want 0", ba.o_Collision); end
  endtask

  task automatic test_reset_override();
    cyc();
    cyc();  // counter at its last count: tick due in the next cycle
    rst = 1'b1;
    ba.i_Load = 1'b1;
    cyc();
    checks++; if (ba.o_Car_X !== '0) begin errors++; $display("FAIL ovr_x: got %h want 0", ba.o_Car_X); end
    checks++; if (ba.o_Car_Y !== '0) begin errors++; $display("FAIL ovr_y: got %h want 0", ba.o_Car_Y); end
    checks++; if (ba.o_Tick !== 1'b0) begin errors++; $display("FAIL ovr_tick: got %b want 0", ba.o_Tick); end
    checks++; if (ba.o_Collision !== '0) begin errors++; $display("FAIL ovr_coll: got %b want 0", ba.o_Collision); end
    rst = 1'b0;
    ba.i_Load = 1'b0;
    cyc();
    checks++; if (ba.o_Car_X !== {6'd7, 6'd0, 6'd5, 6'd5}) begin errors++; $display("FAIL ovr_reload: got %h want %h", ba.o_Car_X, {6'd7, 6'd0, 6'd5, 6'd5}); end
  endtask

  task automatic test_saturate();
    rst_b = 1'b0;
    cyc();
    checks++; if (bb.o_Car_X !== {6'd0, 6'd4, 6'd0, 6'd0}) begin errors++; $display("FAIL sat_load: got %h want %h", bb.o_Car_X, {6'd0, 6'd4, 6'd0, 6'd0}); end
    for (int i = 1; i <= 8; i++) begin
      cyc();
      checks++; if (bb.o_Tick !== (i == 4 || i == 8)) begin errors++; $display("FAIL sat_tick[%0d]: got %b want %b", i, bb.o_Tick, (i == 4 || i == 8)); end
      if (i == 4) begin
        checks++; if (bb.o_Car_X !== {6'd4, 6'd2, 6'd0, 6'd1}) begin errors++; $display("FAIL sat_move1: got %h want %h", bb.o_Car_X, {6'd4, 6'd2, 6'd0, 6'd1}); end
      end
      if (i == 8) begin
        checks++; if (bb.o_Car_X !== {6'd3, 6'd0, 6'd0, 6'd2}) begin errors++; $display("FAIL sat_move2: got %h want %h", bb.o_Car_X, {6'd3, 6'd0, 6'd0, 6'd2}); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_hold();
    test_load_on_tick();
    test_reset_override();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
